// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//
// Shared definitions for the EX-stage forwarding / load-use hazard logic.
//   - REG_ADDR_W_DFLT : default width of a register specifier
//   - fwd_sel_e       : operand-mux select encoding (RF / MEM / WB)
//   - *_shadow_t      : register-tag records kept for the EX, MEM and WB stages
//   - is_producer()   : "this stage will write a real (non-x0) register"
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int REG_ADDR_W_DFLT = 5;

    typedef logic [REG_ADDR_W_DFLT-1:0] reg_addr_t;

    // Matches the 3:1 operand mux; 2'b11 is never produced.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    // EX carries source tags too, because the select is computed for the
    // instruction currently sitting in EX.
    typedef struct packed {
        logic      v;
        reg_addr_t rs1;
        reg_addr_t rs2;
        logic      u1;
        logic      u2;
        reg_addr_t rd;
        logic      wr;
        logic      ld;
    } ex_shadow_t;

    typedef struct packed {
        logic      v;
        reg_addr_t rd;
        logic      wr;
        logic      ld;
    } mem_shadow_t;

    typedef struct packed {
        logic      v;
        reg_addr_t rd;
        logic      wr;
    } wb_shadow_t;

    // x0 is hard-wired to zero, so a write to it never creates a dependence.
    function automatic logic is_producer(input logic v, input logic wr,
                                         input reg_addr_t rd);
        return v & wr & (rd != '0);
    endfunction

endpackage : pipe_pkg

// File: rtl/fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
//
// Combinational comparator that picks the source of one EX-stage ALU operand.
//
// Ports:
//   ex_v_i    : EX holds a real instruction
//   ex_use_i  : EX instruction actually reads this operand
//   ex_src_i  : source register tag of this operand
//   mem_*_i   : MEM-stage shadow tag (valid, writes, is load, rd)
//   wb_*_i    : WB-stage shadow tag (valid, writes, rd)
//   sel_o     : 00 register file, 01 MEM ALU result, 10 WB writeback value
// -----------------------------------------------------------------------------
module fwd_select
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DFLT
) (
    input  logic                  ex_v_i,
    input  logic                  ex_use_i,
    input  logic [REG_ADDR_W-1:0] ex_src_i,
    input  logic                  mem_v_i,
    input  logic                  mem_wr_i,
    input  logic                  mem_ld_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  wb_v_i,
    input  logic                  wb_wr_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    output logic [1:0]            sel_o
);

    logic mem_hit;
    logic wb_hit;

    // A load in MEM has no data yet; the load-use stall pushes its consumer
    // back one cycle so the value is picked up from WB instead.
    assign mem_hit = mem_v_i & mem_wr_i & ~mem_ld_i & (mem_rd_i == ex_src_i);
    assign wb_hit  = wb_v_i & wb_wr_i & (wb_rd_i == ex_src_i);

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch, otherwise an unassigned path infers a latch.
        sel_o = FWD_RF;
        if (ex_v_i && ex_use_i && (ex_src_i != '0)) begin
            // MEM is the younger producer, so it wins over WB.
            if (mem_hit) begin
                sel_o = FWD_MEM;
            end else if (wb_hit) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule : fwd_select

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Keeps an EX/MEM/WB shadow pipeline of register tags, drives the two EX-stage
// operand forwarding selects and detects load-use hazards.
//
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   id_valid          : ID holds a real instruction
//   id_rs1/id_rs2     : ID source registers
//   id_uses_rs1/rs2   : ID instruction reads rs1 / rs2
//   id_rd             : ID destination register
//   id_regWrite       : ID instruction writes rd
//   id_memRead        : ID instruction is a load
//   flush             : taken branch in EX; the ID instruction is killed
//   fwdA_sel/fwdB_sel : operand A / B mux selects for the EX instruction
//   stall             : hold PC and IF/ID this cycle
//   bubble            : ID/EX loads a NOP this cycle
//   stall_count       : saturating count of load-use stall cycles
// -----------------------------------------------------------------------------
module fwd_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DFLT,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regWrite,
    input  logic                  id_memRead,
    input  logic                  flush,
    output logic [1:0]            fwdA_sel,
    output logic [1:0]            fwdB_sel,
    output logic                  stall,
    output logic                  bubble,
    output logic [CNT_W-1:0]      stall_count
);

    ex_shadow_t        ex_q,  ex_d;
    mem_shadow_t       mem_q, mem_d;
    wb_shadow_t        wb_q,  wb_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic ex_is_load;
    logic rs1_dep;
    logic rs2_dep;
    logic hz;

    // ------------------------------------------------------------------
    // Load-use detection against the instruction currently in EX.
    // ------------------------------------------------------------------
    assign ex_is_load = is_producer(ex_q.v, ex_q.wr, ex_q.rd) & ex_q.ld;
    assign rs1_dep    = id_uses_rs1 & (id_rs1 == ex_q.rd);
    assign rs2_dep    = id_uses_rs2 & (id_rs2 == ex_q.rd);
    assign hz         = id_valid & ex_is_load & (rs1_dep | rs2_dep);

    // A flushed ID instruction is discarded, so there is nothing to stall
    // for; the bubble still goes in to kill it.
    assign stall  = hz & ~flush;
    assign bubble = hz | flush;

    // ------------------------------------------------------------------
    // Next state of the shadow pipeline and the stall counter.
    // ------------------------------------------------------------------
    always_comb begin
        ex_d = '0;
        if (!bubble) begin
            ex_d.v   = id_valid;
            ex_d.rs1 = id_rs1;
            ex_d.rs2 = id_rs2;
            ex_d.u1  = id_uses_rs1;
            ex_d.u2  = id_uses_rs2;
            ex_d.rd  = id_rd;
            ex_d.wr  = id_regWrite;
            ex_d.ld  = id_memRead;
        end

        mem_d.v  = ex_q.v;
        mem_d.rd = ex_q.rd;
        mem_d.wr = ex_q.wr;
        mem_d.ld = ex_q.ld;

        wb_d.v   = mem_q.v;
        wb_d.rd  = mem_q.rd;
        wb_d.wr  = mem_q.wr;

        // Saturate instead of wrapping so a long run never reads as "few".
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values; blocking here would let WB see the new MEM.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;

    // ------------------------------------------------------------------
    // Operand selects: purely from shadow registers, stable all EX cycle.
    // ------------------------------------------------------------------
    fwd_select #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_a (
        .ex_v_i   (ex_q.v),
        .ex_use_i (ex_q.u1),
        .ex_src_i (ex_q.rs1),
        .mem_v_i  (mem_q.v),
        .mem_wr_i (mem_q.wr),
        .mem_ld_i (mem_q.ld),
        .mem_rd_i (mem_q.rd),
        .wb_v_i   (wb_q.v),
        .wb_wr_i  (wb_q.wr),
        .wb_rd_i  (wb_q.rd),
        .sel_o    (fwdA_sel)
    );

    fwd_select #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_b (
        .ex_v_i   (ex_q.v),
        .ex_use_i (ex_q.u2),
        .ex_src_i (ex_q.rs2),
        .mem_v_i  (mem_q.v),
        .mem_wr_i (mem_q.wr),
        .mem_ld_i (mem_q.ld),
        .mem_rd_i (mem_q.rd),
        .wb_v_i   (wb_q.v),
        .wb_wr_i  (wb_q.wr),
        .wb_rd_i  (wb_q.rd),
        .sel_o    (fwdB_sel)
    );

endmodule : fwd_hazard_unit
